// File: rtl/seven_seg_pkg.sv
// Shared 7-segment definitions: the active-low glyph table and idle bus constants.
// The display driver imports the same table, so the encoder and decoder always agree.
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_IDLE   = 4'hF;

  // seg[6:0] = g..a, active-low; entry i is the glyph for nibble i
  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic       legal;
    logic [3:0] nibble;
  } glyph_t;

  function automatic logic an_is_lit(input logic [3:0] an);
    return ($countones(~an) == 1);
  endfunction

  function automatic logic [1:0] an_index(input logic [3:0] an);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!an[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational reverse lookup of an active-low segment pattern into a hex nibble.
// Patterns outside the glyph table come back with legal = 0 and nibble = 0.
module seg_glyph_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg,
  output glyph_t     glyph
);

  always_comb begin
    glyph = '0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_GLYPH[i]) begin
        glyph.legal  = 1'b1;
        glyph.nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Loopback monitor for a multiplexed 7-segment bus: recovers the four displayed
// nibbles and decimal points, flags completed frames, repeated digits and a stalled scan.
module seg_scan_decoder
  import seven_seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 400000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  seg_in,
  input  logic [3:0]  an_in,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic [3:0]  digit_valid,
  output logic        frame_done,
  output logic        frame_error,
  output logic        stale
);

  localparam int unsigned SW = $clog2(STABLE_CYCLES);
  localparam int unsigned IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYCLES);
  localparam logic [11:0]   BUS_IDLE = {AN_IDLE, 1'b1, SEG_BLANK};

  logic [3:0]    an_m, an_s;
  logic [7:0]    seg_m, seg_s;
  logic [11:0]   cur, prev;
  logic [SW-1:0] stab_cnt;
  logic          captured;
  logic [3:0]    seen;
  logic [IW-1:0] idle_cnt;

  logic       same, lit, capture;
  logic [1:0] idx;
  logic [3:0] idx_mask;
  glyph_t     glyph;

  seg_glyph_decode u_glyph (
    .seg   (seg_s[6:0]),
    .glyph (glyph)
  );

  assign cur      = {an_s, seg_s};
  assign same     = (cur == prev);
  assign lit      = an_is_lit(an_s);
  assign idx      = an_index(an_s);
  assign idx_mask = 4'b0001 << idx;
  // One capture per dwell: only the first cycle the counter sits at its ceiling
  assign capture  = same && lit && (stab_cnt == STAB_MAX) && !captured;
  assign stale    = (idle_cnt == IDLE_MAX);

  // Input synchronizers and dwell stability tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      an_m     <= AN_IDLE;
      an_s     <= AN_IDLE;
      seg_m    <= {1'b1, SEG_BLANK};
      seg_s    <= {1'b1, SEG_BLANK};
      prev     <= BUS_IDLE;
      stab_cnt <= '0;
      captured <= 1'b0;
    end else begin
      an_m  <= an_in;
      an_s  <= an_m;
      seg_m <= seg_in;
      seg_s <= seg_m;
      prev  <= cur;
      if (!same || !lit) begin
        stab_cnt <= '0;
        captured <= 1'b0;
      end else begin
        if (stab_cnt != STAB_MAX) stab_cnt <= stab_cnt + 1'b1;
        if (capture) captured <= 1'b1;
      end
    end
  end

  // Capture registers, frame tracking and idle timer
  always_ff @(posedge clk) begin
    if (reset) begin
      digits      <= '0;
      dp          <= '0;
      digit_valid <= '0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      seen        <= '0;
      idle_cnt    <= '0;
    end else begin
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      if (capture) begin
        idle_cnt <= '0;
        if (glyph.legal) begin
          digits[{idx, 2'b00} +: 4] <= glyph.nibble;
          digit_valid[idx]          <= 1'b1;
        end else begin
          digit_valid[idx] <= 1'b0;
        end
        dp[idx] <= ~seg_s[7];
        if (seen[idx]) begin
          // A repeat aborts the frame; this capture opens the next one
          frame_error <= 1'b1;
          seen        <= idx_mask;
        end else if ((seen | idx_mask) == 4'hF) begin
          frame_done <= 1'b1;
          seen       <= '0;
        end else begin
          seen[idx] <= 1'b1;
        end
      end else if (idle_cnt != IDLE_MAX) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with short dwell and timeout parameters.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  seg_in = 8'hFF;
  logic [3:0]  an_in = 4'hF;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  digit_valid;
  logic        frame_done;
  logic        frame_error;
  logic        stale;

  int checks = 0;
  int failures = 0;
  int fd_cnt = 0;
  int fe_cnt = 0;
  int fd_base, fe_base;

  seg_scan_decoder #(
    .STABLE_CYCLES  (4),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .digits      (digits),
    .dp          (dp),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .frame_error (frame_error),
    .stale       (stale)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_done)  fd_cnt <= fd_cnt + 1;
    if (frame_error) fe_cnt <= fe_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] an, input logic [7:0] seg, input int n);
    an_in  = an;
    seg_in = seg;
    tick(n);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Digits 0..3 showing 4, 2, E, 0 with decimal points off
  task automatic frame_a(input logic [7:0] seg1);
    drive(4'hE, 8'h99, 20);
    drive(4'hD, seg1, 20);
    drive(4'hB, 8'h86, 20);
    drive(4'h7, 8'hC0, 20);
  endtask

  initial begin
    // Reset state, then exact stale threshold while the bus is blank
    tick(3);
    check("rst_digits", 32'(digits), 32'h0);
    check("rst_dp", 32'(dp), 32'h0);
    check("rst_valid", 32'(digit_valid), 32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    check("rst_frame_error", 32'(frame_error), 32'h0);
    check("rst_stale", 32'(stale), 32'h0);
    reset = 1'b0;
    tick(63);
    check("stale_idle63", 32'(stale), 32'h0);
    tick(1);
    check("stale_idle64", 32'(stale), 32'h1);

    // Basic frame
    fd_base = fd_cnt; fe_base = fe_cnt;
    frame_a(8'hA4);
    check("a_digits", 32'(digits), 32'h0E24);
    check("a_valid", 32'(digit_valid), 32'hF);
    check("a_dp", 32'(dp), 32'h0);
    check("a_frame_done", 32'(fd_cnt - fd_base), 32'd1);
    check("a_frame_error", 32'(fe_cnt - fe_base), 32'd0);
    check("a_stale", 32'(stale), 32'h0);

    // Decimal point on digit 1
    fd_base = fd_cnt;
    frame_a(8'h24);
    check("dp_dp", 32'(dp), 32'b0010);
    check("dp_frame_done", 32'(fd_cnt - fd_base), 32'd1);

    // Long dwell on digit 0 must capture only once
    fd_base = fd_cnt; fe_base = fe_cnt;
    drive(4'hE, 8'h99, 100);
    drive(4'hD, 8'hA4, 20);
    drive(4'hB, 8'h86, 20);
    drive(4'h7, 8'hC0, 20);
    check("long_frame_done", 32'(fd_cnt - fd_base), 32'd1);
    check("long_frame_error", 32'(fe_cnt - fe_base), 32'd0);
    check("long_dp", 32'(dp), 32'h0);

    // Dwells too short to capture: stale rises, captured data holds
    fd_base = fd_cnt; fe_base = fe_cnt;
    for (int i = 0; i < 6; i++) begin
      drive(4'hE, 8'hF9, 3);
      drive(4'hD, 8'hF9, 3);
      drive(4'hB, 8'hF9, 3);
      drive(4'h7, 8'hF9, 3);
    end
    check("short_stale", 32'(stale), 32'h1);
    check("short_digits", 32'(digits), 32'h0E24);
    check("short_valid", 32'(digit_valid), 32'hF);
    check("short_frames", 32'(fd_cnt - fd_base + fe_cnt - fe_base), 32'd0);

    // Illegal glyph on digit 0
    fd_base = fd_cnt;
    drive(4'hE, 8'hFE, 20);
    check("ill_stale_cleared", 32'(stale), 32'h0);
    drive(4'hD, 8'hA4, 20);
    drive(4'hB, 8'h86, 20);
    drive(4'h7, 8'hC0, 20);
    check("ill_digits", 32'(digits), 32'h0E24);
    check("ill_valid", 32'(digit_valid), 32'hE);
    check("ill_frame_done", 32'(fd_cnt - fd_base), 32'd1);

    // Repeat of digit 0 before the frame completes
    fd_base = fd_cnt; fe_base = fe_cnt;
    drive(4'hE, 8'h99, 20);
    drive(4'hD, 8'hA4, 20);
    drive(4'hE, 8'h99, 20);
    check("rep_frame_error", 32'(fe_cnt - fe_base), 32'd1);
    check("rep_no_done0", 32'(fd_cnt - fd_base), 32'd0);
    drive(4'hB, 8'h86, 20);
    drive(4'h7, 8'hC0, 20);
    check("rep_no_done1", 32'(fd_cnt - fd_base), 32'd0);
    drive(4'hD, 8'hA4, 20);
    check("rep_frame_done", 32'(fd_cnt - fd_base), 32'd1);
    check("rep_valid", 32'(digit_valid), 32'hF);

    // Multi-zero anode patterns are not lit
    fd_base = fd_cnt; fe_base = fe_cnt;
    drive(4'h0, 8'hF9, 20);
    drive(4'hC, 8'hF9, 20);
    check("multi_digits", 32'(digits), 32'h0E24);
    check("multi_frames", 32'(fd_cnt - fd_base + fe_cnt - fe_base), 32'd0);

    // Reset mid-dwell; the following capture needs a full dwell after release
    drive(4'hE, 8'hF9, 5);
    reset = 1'b1;
    tick(2);
    check("mid_rst_digits", 32'(digits), 32'h0);
    check("mid_rst_dp", 32'(dp), 32'h0);
    check("mid_rst_valid", 32'(digit_valid), 32'h0);
    check("mid_rst_stale", 32'(stale), 32'h0);
    reset = 1'b0;
    tick(6);
    check("mid_no_early_capture", 32'(digit_valid), 32'h0);
    tick(1);
    check("mid_capture_valid", 32'(digit_valid), 32'h1);
    check("mid_capture_digits", 32'(digits), 32'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
